// File: rtl/apbif_pkg.sv
// Shared types and elaboration helpers for the APB4 register-file bridge.
// Holds the FSM state enum, the data-width legality check and the window decode.
package apbif_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic bit dw_legal(input int dw);
        return (dw == 32) || (dw == 64);
    endfunction

    function automatic bit is_pow2(input logic [63:0] v);
        return (v != 64'd0) && ((v & (v - 64'd1)) == 64'd0);
    endfunction

    // Subtract before comparing so base + span never has to fit in 64 bits.
    function automatic bit in_window(input logic [63:0] addr,
                                     input logic [63:0] base,
                                     input logic [63:0] span);
        return (addr >= base) && ((addr - base) < span);
    endfunction

endpackage

// File: rtl/apb4_regif_bridge_if.sv
// APB4 slave bus plus the register-file handshake, bundled for the bridge.
// slave = bridge side, master = interconnect/register-bank side.
interface apb4_regif_bridge_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            psel;
    logic            penable;
    logic            pwrite;
    logic [AW-1:0]   paddr;
    logic [DW-1:0]   pwdata;
    logic [DW/8-1:0] pstrb;
    logic [DW-1:0]   prdata;
    logic            pready;
    logic            pslverr;

    logic            apbif_req;
    logic            apbif_wr;
    logic [AW-1:0]   apbif_addr;
    logic [DW-1:0]   apbif_wdata;
    logic [DW/8-1:0] apbif_wstrb;
    logic            apbif_ack;
    logic [DW-1:0]   apbif_rdata;
    logic            apbif_err;

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb,
        output prdata, pready, pslverr,
        output apbif_req, apbif_wr, apbif_addr, apbif_wdata, apbif_wstrb,
        input  apbif_ack, apbif_rdata, apbif_err
    );

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb,
        input  prdata, pready, pslverr,
        input  apbif_req, apbif_wr, apbif_addr, apbif_wdata, apbif_wstrb,
        output apbif_ack, apbif_rdata, apbif_err
    );

endinterface

// File: rtl/apbif_tmo_cnt.sv
// Saturating wait-state down-counter; expired flags the last allowed WAIT cycle.
// Reloads while clr is high, so each backend request starts a fresh budget.
module apbif_tmo_cnt #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int            CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LOAD = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= LOAD;
        end else if (clr) begin
            cnt <= LOAD;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign expired = en && (cnt == '0);

endmodule

// File: rtl/apb4_regif_bridge.sv
// APB4 slave to register-file bridge with wait-state handshake and window decode.
// Optional backend timeout is enabled by defining APBIF_TIMEOUT_EN.
//
//   state | meaning
//   IDLE  | waiting for an APB setup phase
//   WAIT  | apbif_req held, waiting for apbif_ack (or timeout)
//   RESP  | pready high for one cycle, pslverr as captured
module apb4_regif_bridge
    import apbif_pkg::*;
#(
    parameter int          AW        = 32,
    parameter int          DW        = 32,
    parameter logic [63:0] BASE_ADDR = 64'd0,
    parameter logic [63:0] ADDR_SPAN = 64'd4096,
    parameter int          TIMEOUT   = 255
) (
    input  logic                pclk,
    input  logic                presetn,
    apb4_regif_bridge_if.slave  bus
);

    localparam int SW = DW / 8;

    if (!dw_legal(DW)) begin : g_dw_check
        $error("apb4_regif_bridge: DW must be 32 or 64");
    end
    if (!is_pow2(ADDR_SPAN)) begin : g_span_check
        $error("apb4_regif_bridge: ADDR_SPAN must be a power of two");
    end
    if (TIMEOUT < 1) begin : g_tmo_check
        $error("apb4_regif_bridge: TIMEOUT must be at least 1");
    end

    state_t          state, state_nxt;
    logic            req_q, req_nxt;
    logic            wr_q, wr_nxt;
    logic [AW-1:0]   addr_q, addr_nxt;
    logic [DW-1:0]   wdata_q, wdata_nxt;
    logic [SW-1:0]   wstrb_q, wstrb_nxt;
    logic [DW-1:0]   prdata_q, prdata_nxt;
    logic            err_q, err_nxt;
    logic            abort_q, abort_nxt;

    logic            setup;
    logic            hit;
    logic [AW-1:0]   offset;
    logic [AW-1:0]   offset_aligned;
    logic            dropped;
    logic            tmo_expired;

    assign setup          = bus.psel && !bus.penable;
    assign hit            = in_window(64'(bus.paddr), BASE_ADDR, ADDR_SPAN);
    assign offset         = bus.paddr - AW'(BASE_ADDR);
    assign offset_aligned = offset & ~AW'(SW - 1);
    // Master abort seen now or in any earlier WAIT cycle.
    assign dropped        = abort_q || !bus.psel;

`ifdef APBIF_TIMEOUT_EN
    apbif_tmo_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo_cnt (
        .clk     (pclk),
        .rst_n   (presetn),
        .clr     (state != WAIT),
        .en      (state == WAIT),
        .expired (tmo_expired)
    );
`else
    assign tmo_expired = 1'b0;
`endif

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state    <= IDLE;
            req_q    <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            prdata_q <= '0;
            err_q    <= 1'b0;
            abort_q  <= 1'b0;
        end else begin
            state    <= state_nxt;
            req_q    <= req_nxt;
            wr_q     <= wr_nxt;
            addr_q   <= addr_nxt;
            wdata_q  <= wdata_nxt;
            wstrb_q  <= wstrb_nxt;
            prdata_q <= prdata_nxt;
            err_q    <= err_nxt;
            abort_q  <= abort_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        req_nxt    = req_q;
        wr_nxt     = wr_q;
        addr_nxt   = addr_q;
        wdata_nxt  = wdata_q;
        wstrb_nxt  = wstrb_q;
        prdata_nxt = prdata_q;
        err_nxt    = err_q;
        abort_nxt  = abort_q;

        case (state)
            IDLE: begin
                if (setup) begin
                    abort_nxt = 1'b0;
                    if (hit) begin
                        req_nxt   = 1'b1;
                        wr_nxt    = bus.pwrite;
                        addr_nxt  = offset_aligned;
                        wdata_nxt = bus.pwdata;
                        wstrb_nxt = bus.pwrite ? bus.pstrb : '0;
                        err_nxt   = 1'b0;
                        state_nxt = WAIT;
                    end else begin
                        // Decode miss never reaches the backend.
                        err_nxt   = 1'b1;
                        state_nxt = RESP;
                        if (!bus.pwrite) begin
                            prdata_nxt = '0;
                        end
                    end
                end
            end

            WAIT: begin
                if (!bus.psel) begin
                    abort_nxt = 1'b1;
                end
                if (bus.apbif_ack) begin
                    req_nxt = 1'b0;
                    err_nxt = bus.apbif_err;
                    if (dropped) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = RESP;
                        if (!wr_q) begin
                            prdata_nxt = bus.apbif_err ? '0 : bus.apbif_rdata;
                        end
                    end
                end else if (tmo_expired) begin
                    req_nxt = 1'b0;
                    err_nxt = 1'b1;
                    if (dropped) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = RESP;
                        if (!wr_q) begin
                            prdata_nxt = '0;
                        end
                    end
                end
            end

            RESP: begin
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
                req_nxt   = 1'b0;
            end
        endcase
    end

    assign bus.prdata      = prdata_q;
    assign bus.pready      = (state == RESP);
    assign bus.pslverr     = (state == RESP) && err_q;
    assign bus.apbif_req   = req_q;
    assign bus.apbif_wr    = wr_q;
    assign bus.apbif_addr  = addr_q;
    assign bus.apbif_wdata = wdata_q;
    assign bus.apbif_wstrb = wstrb_q;

endmodule

// File: tb/tb_apb4_regif_bridge.sv
// Scoreboard bench for apb4_regif_bridge: directed APB transfers, a backend
// responder checking request payloads, and a monitor checking every pready.
`timescale 1ns/1ps
module tb_apb4_regif_bridge;

    localparam logic [31:0] B = 32'h4000_0000;
`ifdef APBIF_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 255;
`endif

    typedef struct {
        int unsigned cyc;
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          n;
        logic [31:0] rdata;
        logic        err;
        bit          hold;
    } be_t;

    logic        pclk;
    logic        presetn;
    int unsigned cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    logic [31:0] model_prdata = 32'h0;
    rsp_t        sb_q[$];
    be_t         be_q[$];
    rsp_t        mr;

    apb4_regif_bridge_if #(.AW(32), .DW(32)) bus ();

    apb4_regif_bridge #(
        .AW        (32),
        .DW        (32),
        .BASE_ADDR (64'(B)),
        .ADDR_SPAN (64'd4096),
        .TIMEOUT   (TMO)
    ) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .bus     (bus.slave)
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    always @(posedge pclk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: actual still running, required finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic outs_zero(input string tag);
        chk({tag, "_prdata"},  64'(bus.prdata),      64'd0);
        chk({tag, "_pready"},  64'(bus.pready),      64'd0);
        chk({tag, "_pslverr"}, 64'(bus.pslverr),     64'd0);
        chk({tag, "_req"},     64'(bus.apbif_req),   64'd0);
        chk({tag, "_wr"},      64'(bus.apbif_wr),    64'd0);
        chk({tag, "_addr"},    64'(bus.apbif_addr),  64'd0);
        chk({tag, "_wdata"},   64'(bus.apbif_wdata), 64'd0);
        chk({tag, "_wstrb"},   64'(bus.apbif_wstrb), 64'd0);
    endtask

    // Backend model: n = ack cycle relative to setup, 0 = no request expected.
    initial begin
        be_t e;
        bus.apbif_ack   = 1'b0;
        bus.apbif_rdata = 32'h0;
        bus.apbif_err   = 1'b0;
        forever begin
            @(negedge pclk);
            if (presetn && bus.apbif_req) begin
                if (be_q.size() == 0) begin
                    chk("unexpected_req", 64'(bus.apbif_req), 64'd0);
                end else begin
                    e = be_q.pop_front();
                    chk("be_wr",    64'(bus.apbif_wr),    64'(e.wr));
                    chk("be_addr",  64'(bus.apbif_addr),  64'(e.addr));
                    chk("be_wstrb", 64'(bus.apbif_wstrb), 64'(e.wstrb));
                    if (e.wr) chk("be_wdata", 64'(bus.apbif_wdata), 64'(e.wdata));
                    repeat (e.n - 1) @(negedge pclk);
                    if (e.hold) chk("be_hold", 64'({bus.apbif_req, bus.apbif_addr}), 64'({1'b1, e.addr}));
                    bus.apbif_rdata = e.rdata;
                    bus.apbif_err   = e.err;
                    bus.apbif_ack   = 1'b1;
                    @(negedge pclk);
                    bus.apbif_ack   = 1'b0;
                    bus.apbif_rdata = 32'h0;
                    bus.apbif_err   = 1'b0;
                end
            end
        end
    end

    always @(negedge pclk) begin
        if (presetn) begin
            if (bus.pready) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_pready", 64'(bus.pready), 64'd0);
                end else begin
                    mr = sb_q.pop_front();
                    chk("pready_cycle", 64'(cyc),         64'(mr.cyc));
                    chk("pslverr",      64'(bus.pslverr), 64'(mr.err));
                    chk("prdata",       64'(bus.prdata),  64'(mr.rdata));
                    chk("req_in_resp",  64'(bus.apbif_req), 64'd0);
                end
            end else begin
                chk("pslverr_idle", 64'(bus.pslverr), 64'd0);
            end
        end
    end

    // Called #1 after a rising edge; that cycle is the setup cycle T0.
    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb, input int n, input logic [31:0] rdata,
                            input logic be_err, input logic [31:0] exp_off, input int exp_lat,
                            input logic exp_err, input bit hold, input bit abort);
        rsp_t r;
        be_t  b;
        bit   got;
        if (n > 0) begin
            b = '{wr: wr, addr: exp_off, wdata: wdata, wstrb: wr ? strb : 4'b0000,
                  n: n, rdata: rdata, err: be_err, hold: hold};
            be_q.push_back(b);
        end
        if (!abort) begin
            if (!wr) model_prdata = exp_err ? 32'h0 : rdata;
            r = '{cyc: cyc + exp_lat, err: exp_err, rdata: model_prdata};
            sb_q.push_back(r);
        end
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite  = wr;
        bus.paddr   = addr;
        bus.pwdata  = wdata;
        bus.pstrb   = strb;
        @(posedge pclk); #1;
        bus.penable = 1'b1;
        if (abort) begin
            @(posedge pclk); #1;
            bus.psel    = 1'b0;
            bus.penable = 1'b0;
            repeat (n + 2) @(posedge pclk);
            #1;
        end else begin
            got = 1'b0;
            for (int i = 0; i < 300 && !got; i++) begin
                @(negedge pclk);
                got = bus.pready;
            end
            if (!got) begin
                n_chk++;
                $display("FAIL pready_wait: actual no pready in 300 cycles, required pready");
            end
            @(posedge pclk); #1;
            bus.psel    = 1'b0;
            bus.penable = 1'b0;
        end
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) @(posedge pclk);
        #1;
    endtask

    initial begin
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b0;
        bus.paddr   = 32'h0;
        bus.pwdata  = 32'h0;
        bus.pstrb   = 4'h0;
        presetn     = 1'b0;
        repeat (2) @(negedge pclk);
        outs_zero("reset");
        presetn = 1'b1;
        idle(2);

        //       wr    addr         wdata          strb     n  rdata          err   off        lat err hold abort
        apb_xfer(1'b1, B + 32'h10,  32'hA5A5_1234, 4'b0011, 1, 32'h0,         1'b0, 32'h10,    2, 1'b0, 1, 0);
        apb_xfer(1'b0, B + 32'h20,  32'h0,         4'b1111, 5, 32'hDEAD_BEEF, 1'b0, 32'h20,    6, 1'b0, 1, 0);
        apb_xfer(1'b0, B + 32'h1000, 32'h0,        4'b1111, 0, 32'h0,         1'b0, 32'h0,     1, 1'b1, 0, 0);
        apb_xfer(1'b1, B - 32'h4,   32'h5555_5555, 4'b1111, 0, 32'h0,         1'b0, 32'h0,     1, 1'b1, 0, 0);
        apb_xfer(1'b0, B + 32'h24,  32'h0,         4'b0000, 2, 32'h1234_5678, 1'b1, 32'h24,    3, 1'b1, 1, 0);
        apb_xfer(1'b1, B + 32'h30,  32'hCAFE_0001, 4'b1111, 3, 32'h0,         1'b0, 32'h30,    4, 1'b0, 1, 0);
        apb_xfer(1'b0, B + 32'h23,  32'h0,         4'b0000, 1, 32'hCAFE_F00D, 1'b0, 32'h20,    2, 1'b0, 1, 0);
        apb_xfer(1'b0, B + 32'hFFC, 32'h0,         4'b0000, 1, 32'h0BAD_F00D, 1'b0, 32'hFFC,   2, 1'b0, 1, 0);
        apb_xfer(1'b0, B + 32'h40,  32'h0,         4'b0000, 6, 32'h1111_1111, 1'b0, 32'h40,    0, 1'b0, 1, 1);
        apb_xfer(1'b1, B + 32'h44,  32'h0000_AB00, 4'b0100, 2, 32'h0,         1'b0, 32'h44,    3, 1'b0, 1, 0);
        apb_xfer(1'b1, B + 32'h48,  32'h0000_0077, 4'b0001, 1, 32'h0,         1'b1, 32'h48,    2, 1'b1, 1, 0);
        idle(2);
`ifdef APBIF_TIMEOUT_EN
        apb_xfer(1'b0, B + 32'h60,  32'h0,         4'b0000, 10, 32'h7777_0001, 1'b0, 32'h60,   9, 1'b1, 0, 0);
`else
        apb_xfer(1'b0, B + 32'h60,  32'h0,         4'b0000, 120, 32'h7777_0001, 1'b0, 32'h60, 121, 1'b0, 1, 0);
`endif
        idle(6);

        be_q.push_back('{wr: 1'b0, addr: 32'h50, wdata: 32'h0, wstrb: 4'b0000,
                         n: 6, rdata: 32'h9999_9999, err: 1'b0, hold: 1'b0});
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b0;
        bus.paddr   = B + 32'h50;
        @(posedge pclk); #1;
        bus.penable = 1'b1;
        @(posedge pclk);
        @(posedge pclk); #3;
        presetn = 1'b0;
        #1;
        outs_zero("rst_wait");
        bus.psel     = 1'b0;
        bus.penable  = 1'b0;
        model_prdata = 32'h0;
        @(negedge pclk);
        presetn = 1'b1;
        idle(8);

        apb_xfer(1'b0, B + 32'h8,   32'h0,         4'b0000, 2, 32'h600D_CAFE, 1'b0, 32'h8,     3, 1'b0, 1, 0);
        apb_xfer(1'b1, B + 32'hC,   32'h0102_0304, 4'b1001, 1, 32'h0,         1'b0, 32'hC,     2, 1'b0, 1, 0);
        idle(5);

        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        chk("be_drained", 64'(be_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
